bcd_converter_16bit: RTL and testbench

Sequential binary-to-BCD converter directly downstream of the 8x8 combinational multiplier. Captures the 16-bit `PRODUCT` on a start strobe and runs a shift-and-add-3 (double-dabble) sequence, one bit per clock. Presents five packed BCD digits to the calculator display/output stage with a one-cycle completion pulse.

---
 rtl/calc_pkg.sv | 16 +
 rtl/bcd_digit_adj.sv | 17 +
 rtl/bcd_converter_16bit.sv | 95 +++++++++
 tb/tb_bcd_converter_16bit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared calculator datapath definitions: converter state encoding and widths
// common to the multiplier, BCD converter and display stages.
package calc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StFinish
  } conv_state_e;

  localparam int unsigned BCD_DIGITS = 5;
  localparam int unsigned PROD_W     = 16;

  localparam logic [3:0] ADD3_THRESH = 4'd5;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
  import calc_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= ADD3_THRESH) begin
      digit_o = digit_i + 4'd3;
    end
  end

endmodule

// File: rtl/bcd_converter_16bit.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock,
// with a registered result and a one-cycle completion pulse.
module bcd_converter_16bit
  import calc_pkg::*;
#(
  parameter int unsigned IN_W   = PROD_W,
  parameter int unsigned DIGITS = BCD_DIGITS
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic [IN_W-1:0]       BIN,
  output logic [4*DIGITS-1:0]   BCD,
  output logic                  DONE,
  output logic                  BUSY
);

  localparam int unsigned CntW = $clog2(IN_W);
  localparam int unsigned ScrW = 4 * DIGITS;
  localparam logic [CntW-1:0] CntLast = CntW'(IN_W - 1);

  conv_state_e     state_q, state_d;
  logic [IN_W-1:0] shift_bin_q, shift_bin_d;
  logic [ScrW-1:0] scratch_q, scratch_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [ScrW-1:0] bcd_q, bcd_d;

  logic [ScrW-1:0]      scratch_adj;
  logic [ScrW+IN_W-1:0] shifted;

  // All digits are corrected in parallel from the pre-shift scratch value.
  for (genvar g = 0; g < DIGITS; g++) begin : gen_adj
    bcd_digit_adj u_adj (
      .digit_i (scratch_q[4*g +: 4]),
      .digit_o (scratch_adj[4*g +: 4])
    );
  end

  assign shifted = {scratch_adj, shift_bin_q} << 1;

  always_comb begin
    state_d     = state_q;
    shift_bin_d = shift_bin_q;
    scratch_d   = scratch_q;
    cnt_d       = cnt_q;
    bcd_d       = bcd_q;

    unique case (state_q)
      StIdle: begin
        if (START) begin
          shift_bin_d = BIN;
          scratch_d   = '0;
          cnt_d       = '0;
          state_d     = StShift;
        end
      end
      StShift: begin
        scratch_d   = shifted[ScrW+IN_W-1:IN_W];
        shift_bin_d = shifted[IN_W-1:0];
        cnt_d       = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          bcd_d   = shifted[ScrW+IN_W-1:IN_W];
          state_d = StFinish;
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= StIdle;
      shift_bin_q <= '0;
      scratch_q   <= '0;
      cnt_q       <= '0;
      bcd_q       <= '0;
    end else begin
      state_q     <= state_d;
      shift_bin_q <= shift_bin_d;
      scratch_q   <= scratch_d;
      cnt_q       <= cnt_d;
      bcd_q       <= bcd_d;
    end
  end

  assign BCD  = bcd_q;
  assign DONE = (state_q == StFinish);
  assign BUSY = (state_q != StIdle);

endmodule

// File: tb/tb_bcd_converter_16bit.sv
// Self-checking bench for bcd_converter_16bit: directed vector table, random
// sweep against a decimal model, and hand-written multi-cycle corner sequences.
module tb_bcd_converter_16bit;

  logic        CLK;
  logic        RST_N;
  logic        START;
  logic [15:0] BIN;
  logic [19:0] BCD;
  logic        DONE;
  logic        BUSY;

  int passed = 0;
  int total  = 0;

  bcd_converter_16bit dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .START (START),
    .BIN   (BIN),
    .BCD   (BCD),
    .DONE  (DONE),
    .BUSY  (BUSY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic [15:0] bin;
    logic [19:0] bcd;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  function automatic logic [19:0] dec_model(input int unsigned v);
    logic [19:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int d = 0; d < 5; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Starts one conversion from IDLE and follows it until BUSY drops (bounded).
  // Sample index 0 is the first falling edge after the accept edge.
  task automatic run_conv(input logic [15:0] bin, output logic [19:0] res,
                          output int done_idx, output int busy_cnt, output int done_cnt);
    @(negedge CLK);
    START = 1'b1;
    BIN   = bin;
    @(negedge CLK);
    START    = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    done_idx = -1;
    for (int i = 0; i < 40; i++) begin
      if (BUSY) busy_cnt++;
      if (DONE) begin
        done_cnt++;
        if (done_idx < 0) done_idx = i;
      end
      if (i > 0 && !BUSY) break;
      @(negedge CLK);
    end
    res = BCD;
  endtask

  initial begin
    logic [19:0] res;
    logic [15:0] rv;
    int done_idx, busy_cnt, done_cnt;
    int ndone;
    int done_at[3];
    logic [19:0] done_bcd[3];

    vecs[0] = '{16'd0,     20'h00000};
    vecs[1] = '{16'd65535, 20'h65535};
    vecs[2] = '{16'd65025, 20'h65025};
    vecs[3] = '{16'd9,     20'h00009};
    vecs[4] = '{16'd10,    20'h00010};
    vecs[5] = '{16'd99,    20'h00099};
    vecs[6] = '{16'd100,   20'h00100};
    vecs[7] = '{16'd9999,  20'h09999};
    vecs[8] = '{16'd10000, 20'h10000};
    vecs[9] = '{16'd12345, 20'h12345};

    RST_N = 1'b0;
    START = 1'b0;
    BIN   = '0;
    #1;
    check("reset_bcd", 32'(BCD), 32'h0);
    check("reset_done", 32'(DONE), 32'h0);
    check("reset_busy", 32'(BUSY), 32'h0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;

    // DONE lands 16 edges after accept (17-cycle latency incl. accept cycle).
    for (int v = 0; v < 10; v++) begin
      run_conv(vecs[v].bin, res, done_idx, busy_cnt, done_cnt);
      check($sformatf("vec%0d_bcd", v), 32'(res), 32'(vecs[v].bcd));
      check($sformatf("vec%0d_done_idx", v), 32'(done_idx), 32'd16);
      check($sformatf("vec%0d_busy_cycles", v), 32'(busy_cnt), 32'd17);
      check($sformatf("vec%0d_done_count", v), 32'(done_cnt), 32'd1);
    end

    for (int n = 0; n < 1000; n++) begin
      rv = 16'($urandom);
      run_conv(rv, res, done_idx, busy_cnt, done_cnt);
      check($sformatf("rand_%0d", rv), 32'(res), 32'(dec_model(32'(rv))));
    end

    // START with changed BIN during SHIFT (sample 3) and FINISH (sample 16).
    @(negedge CLK);
    START = 1'b1;
    BIN   = 16'd1234;
    @(negedge CLK);
    START    = 1'b0;
    BIN      = 16'd999;
    done_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      if (DONE) done_cnt++;
      START = (i == 3 || i == 16);
      if (START) BIN = 16'd4000 + 16'(i);
      @(negedge CLK);
    end
    START = 1'b0;
    check("ignore_bcd", 32'(BCD), 32'h01234);
    check("ignore_done_count", 32'(done_cnt), 32'd1);
    check("ignore_idle", 32'(BUSY), 32'h0);

    // Reset partway through converting 12345 aborts it.
    @(negedge CLK);
    START = 1'b1;
    BIN   = 16'd12345;
    @(negedge CLK);
    START = 1'b0;
    repeat (8) @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check("abort_bcd", 32'(BCD), 32'h0);
    check("abort_busy", 32'(BUSY), 32'h0);
    check("abort_done", 32'(DONE), 32'h0);
    @(negedge CLK);
    RST_N    = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge CLK);
      if (DONE) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    run_conv(16'd4321, res, done_idx, busy_cnt, done_cnt);
    check("after_abort_bcd", 32'(res), 32'h04321);

    // START held high: back-to-back conversions of 1, 2, 3.
    @(negedge CLK);
    START = 1'b1;
    BIN   = 16'd1;
    ndone = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge CLK);
      if (DONE) begin
        done_at[ndone]  = i;
        done_bcd[ndone] = BCD;
        ndone++;
        BIN = 16'(ndone + 1);
        if (ndone == 3) break;
      end
    end
    START = 1'b0;
    check("b2b_done_count", 32'(ndone), 32'd3);
    if (ndone == 3) begin
      check("b2b_bcd0", 32'(done_bcd[0]), 32'h00001);
      check("b2b_bcd1", 32'(done_bcd[1]), 32'h00002);
      check("b2b_bcd2", 32'(done_bcd[2]), 32'h00003);
      check("b2b_gap01", 32'(done_at[1] - done_at[0]), 32'd18);
      check("b2b_gap12", 32'(done_at[2] - done_at[1]), 32'd18);
    end
    repeat (2) @(negedge CLK);
    check("b2b_idle", 32'(BUSY), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
